// File: rtl/cpu_bus_lockstep_cmp.sv
// Lockstep checker: buffers DUV and reference bus transactions per side and compares them pairwise in order.
// Latency: a pair is popped once both sides hold an entry; counters/mismatch/first_* update at that same edge.
// Backpressure: none upstream; a push into a full FIFO is dropped and raises overflow (ERROR).

module lockstep_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Extra pointer bit separates full from empty when the index bits coincide.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_rdy)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end
endmodule

module cpu_bus_lockstep_cmp #(
    parameter int ADDR_W           = 16,
    parameter int DATA_W           = 8,
    parameter int DEPTH            = 16,
    parameter int CNT_W            = 16,
    parameter int TIMEOUT          = 64,
    parameter bit STOP_ON_MISMATCH = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              duv_valid,
    input  logic [ADDR_W-1:0] duv_addr,
    input  logic [DATA_W-1:0] duv_data,
    input  logic              duv_rw,
    input  logic              ref_valid,
    input  logic [ADDR_W-1:0] ref_addr,
    input  logic [DATA_W-1:0] ref_data,
    input  logic              ref_rw,
    output logic              mismatch,
    output logic [CNT_W-1:0]  match_count,
    output logic [CNT_W-1:0]  mismatch_count,
    output logic              first_valid,
    output logic [ADDR_W-1:0] first_addr,
    output logic [DATA_W-1:0] first_duv_data,
    output logic [DATA_W-1:0] first_ref_data,
    output logic              overflow,
    output logic              timeout,
    output logic [1:0]        state
);
    localparam int EW = ADDR_W + DATA_W + 1;
    localparam int SW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0]    SKEW_LAST = SW'(TIMEOUT - 1);
    localparam logic [SW-1:0]    SKEW_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t         cur_state;
    state_t         nxt_state;
    logic [SW-1:0]  skew_cnt;
    logic [EW-1:0]  duv_head;
    logic [EW-1:0]  ref_head;
    logic           duv_empty, duv_full, ref_empty, ref_full;
    logic           run, pop, pair_diff, duv_push, ref_push;
    logic           ovf_hit, skew_cond, skew_hit;

    lockstep_fifo #(.W(EW), .DEPTH(DEPTH)) u_duv_fifo (
        .clk(clk), .rst(rst),
        .push_vld(duv_push), .push_dat({duv_addr, duv_data, duv_rw}),
        .pop_rdy(pop), .pop_dat(duv_head),
        .empty(duv_empty), .full(duv_full)
    );

    lockstep_fifo #(.W(EW), .DEPTH(DEPTH)) u_ref_fifo (
        .clk(clk), .rst(rst),
        .push_vld(ref_push), .push_dat({ref_addr, ref_data, ref_rw}),
        .pop_rdy(pop), .pop_dat(ref_head),
        .empty(ref_empty), .full(ref_full)
    );

    assign state     = cur_state;
    assign run       = (cur_state == S_RUN);
    assign pop       = run && !duv_empty && !ref_empty;
    // A full side can still take a push when the pair pop frees a slot this cycle.
    assign duv_push  = run && duv_valid && (!duv_full || pop);
    assign ref_push  = run && ref_valid && (!ref_full || pop);
    assign ovf_hit   = run && !pop && ((duv_valid && duv_full) || (ref_valid && ref_full));
    assign pair_diff = (duv_head != ref_head);
    assign skew_cond = run && (duv_empty != ref_empty);
    assign skew_hit  = skew_cond && (skew_cnt == SKEW_LAST);

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_IDLE: begin
                if (enable) nxt_state = S_RUN;
            end
            S_RUN: begin
                if (ovf_hit || skew_hit)                       nxt_state = S_ERROR;
                else if (pop && pair_diff && STOP_ON_MISMATCH) nxt_state = S_HALT;
                else if (!enable)                              nxt_state = S_IDLE;
            end
            default: nxt_state = cur_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state      <= S_IDLE;
            mismatch       <= 1'b0;
            match_count    <= '0;
            mismatch_count <= '0;
            first_valid    <= 1'b0;
            first_addr     <= '0;
            first_duv_data <= '0;
            first_ref_data <= '0;
            overflow       <= 1'b0;
            timeout        <= 1'b0;
            skew_cnt       <= '0;
        end else begin
            cur_state <= nxt_state;
            mismatch  <= pop && pair_diff;
            if (pop && !pair_diff && (match_count != '1)) begin
                match_count <= match_count + CNT_ONE;
            end
            if (pop && pair_diff) begin
                if (mismatch_count != '1) mismatch_count <= mismatch_count + CNT_ONE;
                if (!first_valid) begin
                    first_valid    <= 1'b1;
                    first_addr     <= duv_head[EW-1 -: ADDR_W];
                    first_duv_data <= duv_head[DATA_W:1];
                    first_ref_data <= ref_head[DATA_W:1];
                end
            end
            if (ovf_hit)  overflow <= 1'b1;
            if (skew_hit) timeout  <= 1'b1;
            // Skew only advances while running; IDLE keeps the count for resume.
            if (run) skew_cnt <= skew_cond ? (skew_cnt + SKEW_ONE) : '0;
        end
    end
endmodule

// File: tb/tb_cpu_bus_lockstep_cmp.sv
// Bench for cpu_bus_lockstep_cmp: directed scenarios on a halting instance plus a queue-based model
// tracking a non-halting, narrow-counter instance every cycle.
module tb_cpu_bus_lockstep_cmp;
    localparam int DEPTH    = 16;
    localparam int TIMEOUT  = 64;
    localparam int NS_CNT_W = 5;
    localparam int NS_MAX   = (1 << NS_CNT_W) - 1;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        rw;
    } txn_t;

    typedef struct {
        txn_t d;
        txn_t r;
        bit   exp_mis;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, enable, duv_valid, ref_valid, duv_rw, ref_rw;
    logic [15:0] duv_addr, ref_addr;
    logic [7:0]  duv_data, ref_data;

    logic        s_mismatch, s_fv, s_ovf, s_to;
    logic [15:0] s_match, s_mism, s_faddr;
    logic [7:0]  s_fdd, s_frd;
    logic [1:0]  s_state;

    logic                n_mismatch, n_fv, n_ovf, n_to;
    logic [NS_CNT_W-1:0] n_match, n_mism;
    logic [15:0]         n_faddr;
    logic [7:0]          n_fdd, n_frd;
    logic [1:0]          n_state;

    int n_checks = 0;
    int n_fail   = 0;
    int s_pulses = 0;

    always #5 clk = ~clk;

    cpu_bus_lockstep_cmp #(.ADDR_W(16), .DATA_W(8), .DEPTH(DEPTH), .CNT_W(16),
                           .TIMEOUT(TIMEOUT), .STOP_ON_MISMATCH(1'b1)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .duv_valid(duv_valid), .duv_addr(duv_addr), .duv_data(duv_data), .duv_rw(duv_rw),
        .ref_valid(ref_valid), .ref_addr(ref_addr), .ref_data(ref_data), .ref_rw(ref_rw),
        .mismatch(s_mismatch), .match_count(s_match), .mismatch_count(s_mism),
        .first_valid(s_fv), .first_addr(s_faddr), .first_duv_data(s_fdd), .first_ref_data(s_frd),
        .overflow(s_ovf), .timeout(s_to), .state(s_state)
    );

    cpu_bus_lockstep_cmp #(.ADDR_W(16), .DATA_W(8), .DEPTH(DEPTH), .CNT_W(NS_CNT_W),
                           .TIMEOUT(TIMEOUT), .STOP_ON_MISMATCH(1'b0)) dut_ns (
        .clk(clk), .rst(rst), .enable(enable),
        .duv_valid(duv_valid), .duv_addr(duv_addr), .duv_data(duv_data), .duv_rw(duv_rw),
        .ref_valid(ref_valid), .ref_addr(ref_addr), .ref_data(ref_data), .ref_rw(ref_rw),
        .mismatch(n_mismatch), .match_count(n_match), .mismatch_count(n_mism),
        .first_valid(n_fv), .first_addr(n_faddr), .first_duv_data(n_fdd), .first_ref_data(n_frd),
        .overflow(n_ovf), .timeout(n_to), .state(n_state)
    );

    // Reference model for the non-halting instance: transaction queues and plain counters.
    txn_t m_dq[$];
    txn_t m_rq[$];
    int   m_state, m_match, m_mism, m_skew;
    bit   m_pulse, m_fv, m_ovf, m_to;
    txn_t m_first_d, m_first_r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit en, input bit dv, input txn_t dt,
                              input bit rv, input txn_t rt);
        bit   lone, popped, ovf, hit, diff;
        txn_t a, b;
        if (r) begin
            m_dq.delete(); m_rq.delete();
            m_state = 0; m_match = 0; m_mism = 0; m_skew = 0;
            m_pulse = 0; m_fv = 0; m_ovf = 0; m_to = 0;
            m_first_d = '0; m_first_r = '0;
            return;
        end
        m_pulse = 0;
        if (m_state == 1) begin
            lone   = (m_dq.size() == 0) != (m_rq.size() == 0);
            popped = (m_dq.size() > 0) && (m_rq.size() > 0);
            diff   = 0;
            if (popped) begin
                a = m_dq.pop_front();
                b = m_rq.pop_front();
                diff = (a != b);
                if (!diff) begin
                    if (m_match < NS_MAX) m_match++;
                end else begin
                    if (m_mism < NS_MAX) m_mism++;
                    m_pulse = 1;
                    if (!m_fv) begin m_fv = 1; m_first_d = a; m_first_r = b; end
                end
            end
            ovf = 0;
            if (dv) begin if (m_dq.size() < DEPTH) m_dq.push_back(dt); else ovf = 1; end
            if (rv) begin if (m_rq.size() < DEPTH) m_rq.push_back(rt); else ovf = 1; end
            hit = 0;
            if (lone) begin m_skew++; hit = (m_skew == TIMEOUT); end
            else m_skew = 0;
            if (ovf) m_ovf = 1;
            if (hit) m_to = 1;
            if (ovf || hit) m_state = 3;
            else if (!en)   m_state = 0;
        end else if (m_state == 0 && en) begin
            m_state = 1;
        end
    endtask

    task automatic check_model();
        chk("model state", 32'(n_state), 32'(m_state));
        chk("model match_count", 32'(n_match), 32'(m_match));
        chk("model mismatch_count", 32'(n_mism), 32'(m_mism));
        chk("model mismatch", 32'(n_mismatch), 32'(m_pulse));
        chk("model first_valid", 32'(n_fv), 32'(m_fv));
        chk("model first_addr", 32'(n_faddr), 32'(m_first_d.addr));
        chk("model first_duv_data", 32'(n_fdd), 32'(m_first_d.data));
        chk("model first_ref_data", 32'(n_frd), 32'(m_first_r.data));
        chk("model overflow", 32'(n_ovf), 32'(m_ovf));
        chk("model timeout", 32'(n_to), 32'(m_to));
    endtask

    task automatic cyc(input bit r, input bit en, input bit dv, input txn_t dt,
                       input bit rv, input txn_t rt);
        rst = r; enable = en;
        duv_valid = dv; {duv_addr, duv_data, duv_rw} = dt;
        ref_valid = rv; {ref_addr, ref_data, ref_rw} = rt;
        model_step(r, en, dv, dt, rv, rt);
        @(posedge clk);
        #1;
        check_model();
        if (s_mismatch) s_pulses++;
    endtask

    function automatic txn_t mk(input logic [15:0] a, input logic [7:0] d, input logic w);
        txn_t t;
        t.addr = a; t.data = d; t.rw = w;
        return t;
    endfunction

    task automatic idle(input bit en, input int n);
        for (int i = 0; i < n; i++) cyc(0, en, 0, '0, 0, '0);
    endtask

    task automatic start();
        cyc(1, 0, 0, '0, 0, '0);
        cyc(0, 1, 0, '0, 0, '0);
    endtask

    vec_t vecs[8];
    txn_t rnd_d[512];
    txn_t rnd_r[512];

    initial begin
        int exp_mis_total;
        int di, ri;
        int pd, pr;
        txn_t t, u;

        vecs[0] = '{mk(16'h1234, 8'hA5, 1'b1), mk(16'h1234, 8'hA5, 1'b1), 1'b0};
        vecs[1] = '{mk(16'h1234, 8'hA5, 1'b1), mk(16'h1235, 8'hA5, 1'b1), 1'b1};
        vecs[2] = '{mk(16'h0000, 8'h00, 1'b0), mk(16'h0000, 8'h00, 1'b0), 1'b0};
        vecs[3] = '{mk(16'h8000, 8'h7F, 1'b0), mk(16'h8000, 8'hFF, 1'b0), 1'b1};
        vecs[4] = '{mk(16'hFFFF, 8'hFF, 1'b1), mk(16'hFFFF, 8'hFF, 1'b0), 1'b1};
        vecs[5] = '{mk(16'hFFFF, 8'hFF, 1'b1), mk(16'hFFFF, 8'hFF, 1'b1), 1'b0};
        vecs[6] = '{mk(16'h0001, 8'h10, 1'b0), mk(16'h8001, 8'h10, 1'b0), 1'b1};
        vecs[7] = '{mk(16'h5A5A, 8'h3C, 1'b1), mk(16'hA5A5, 8'hC3, 1'b0), 1'b1};

        // Reset state and IDLE ignoring valids
        cyc(1, 0, 1, mk(16'h1, 8'h1, 1'b1), 1, mk(16'h1, 8'h1, 1'b1));
        chk("reset state", 32'(s_state), 0);
        chk("reset match_count", 32'(s_match), 0);
        chk("reset first_valid", 32'(s_fv), 0);
        cyc(0, 0, 1, mk(16'h2, 8'h2, 1'b0), 0, '0);
        cyc(0, 1, 1, mk(16'h3, 8'h3, 1'b0), 0, '0);
        idle(1, 3);
        chk("idle ignores valid match", 32'(s_match), 0);
        chk("idle ignores valid mism", 32'(s_mism), 0);
        chk("idle to run", 32'(s_state), 1);

        // 100 identical transactions in lockstep
        start();
        for (int i = 0; i < 100; i++) begin
            t = mk(16'(i * 3), 8'(i), 1'(i));
            cyc(0, 1, 1, t, 1, t);
        end
        idle(1, 3);
        chk("t1 match_count", 32'(s_match), 100);
        chk("t1 mismatch_count", 32'(s_mism), 0);
        chk("t1 state", 32'(s_state), 1);
        chk("t1 narrow counter saturates", 32'(n_match), NS_MAX);

        // Reference delayed by 5 cycles
        start();
        for (int c = 0; c < 55; c++) begin
            cyc(0, 1, c < 50, mk(16'(16'h4000 + c), 8'(c * 7), 1'(c)),
                c >= 5, mk(16'(16'h4000 + c - 5), 8'((c - 5) * 7), 1'(c - 5)));
        end
        idle(1, 3);
        chk("t2 match_count", 32'(s_match), 50);
        chk("t2 mismatch_count", 32'(s_mism), 0);
        chk("t2 timeout", 32'(s_to), 0);

        // First mismatch halts the stopping instance
        start();
        s_pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            t = mk(16'(16'h7FFC + i), 8'(8'h36 + i), 1'(i));
            u = t;
            if (i == 7) u.data = 8'h3C;
            cyc(0, 1, 1, t, 1, u);
        end
        idle(1, 3);
        chk("t3 mismatch pulse cycles", 32'(s_pulses), 1);
        chk("t3 first_valid", 32'(s_fv), 1);
        chk("t3 first_addr", 32'(s_faddr), 32'h8003);
        chk("t3 first_duv_data", 32'(s_fdd), 32'h3D);
        chk("t3 first_ref_data", 32'(s_frd), 32'h3C);
        chk("t3 state", 32'(s_state), 2);
        chk("t3 match_count", 32'(s_match), 6);
        chk("t3 nonstop match_count", 32'(n_match), 9);

        // Non-halting instance keeps comparing
        start();
        for (int i = 1; i <= 20; i++) begin
            t = mk(16'(16'h1000 + i * 16'h11), 8'(i), 1'b0);
            u = t;
            if (i == 3 || i == 9) u.data = u.data ^ 8'h01;
            cyc(0, 1, 1, t, 1, u);
        end
        idle(1, 3);
        chk("t4 mismatch_count", 32'(n_mism), 2);
        chk("t4 match_count", 32'(n_match), 18);
        chk("t4 first_addr", 32'(n_faddr), 32'(16'h1000 + 3 * 16'h11));
        chk("t4 state", 32'(n_state), 1);

        // Overflow on the 17th push
        start();
        for (int i = 0; i < 17; i++) begin
            if (i == 16) chk("t5 no overflow at full", 32'(s_ovf), 0);
            cyc(0, 1, 1, mk(16'(i), 8'(i), 1'b1), 0, '0);
        end
        idle(1, 1);
        chk("t5 overflow", 32'(s_ovf), 1);
        chk("t5 state error", 32'(s_state), 3);

        // Push into full FIFO with a same-cycle pop is accepted
        start();
        for (int c = 0; c < 33; c++) begin
            cyc(0, 1, c < 16 || c == 17, mk(16'(16'h2000 + (c == 17 ? 16 : c)), 8'(c), 1'b0),
                c >= 16, mk(16'(16'h2000 + c - 16), 8'(c == 16 ? 0 : (c == 33 ? 0 : (c - 16 == 16 ? 17 : c - 16))), 1'b0));
        end
        idle(1, 3);
        chk("t5b overflow", 32'(s_ovf), 0);
        chk("t5b state", 32'(s_state), 1);
        chk("t5b match_count", 32'(s_match), 17);

        // Skew timeout boundary
        start();
        cyc(0, 1, 1, mk(16'h55, 8'h55, 1'b1), 0, '0);
        idle(1, TIMEOUT - 1);
        chk("t5c timeout before limit", 32'(s_to), 0);
        idle(1, 1);
        chk("t5c timeout", 32'(s_to), 1);
        chk("t5c state", 32'(s_state), 3);

        // Reset mid-stream with entries buffered
        start();
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, mk(16'(i), 8'(i), 1'b1), 1, mk(16'(i), 8'(i), 1'b1));
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, mk(16'(16'h90 + i), 8'(i), 1'b0), 0, '0);
        cyc(1, 1, 0, '0, 0, '0);
        chk("t6 state", 32'(s_state), 0);
        chk("t6 match_count", 32'(s_match), 0);
        chk("t6 mismatch", 32'(s_mismatch), 0);
        chk("t6 overflow", 32'(s_ovf), 0);
        chk("t6 timeout", 32'(s_to), 0);
        cyc(0, 1, 0, '0, 0, '0);
        cyc(0, 1, 0, '0, 1, mk(16'h90, 8'h0, 1'b0));
        idle(1, 3);
        chk("t6 fifo flushed match", 32'(s_match), 0);
        chk("t6 fifo flushed mism", 32'(s_mism), 0);

        // enable=0 parks in IDLE keeping contents; resume completes the pair
        start();
        cyc(0, 1, 1, mk(16'hBEEF, 8'h42, 1'b1), 0, '0);
        cyc(0, 0, 0, '0, 0, '0);
        cyc(0, 0, 0, '0, 1, mk(16'hBEEF, 8'h42, 1'b1));
        chk("t7 parked idle", 32'(s_state), 0);
        cyc(0, 1, 0, '0, 0, '0);
        cyc(0, 1, 0, '0, 1, mk(16'hBEEF, 8'h42, 1'b1));
        idle(1, 2);
        chk("t7 resume match", 32'(s_match), 1);
        chk("t7 resume state", 32'(s_state), 1);

        // Table of single-pair compares on the non-halting instance
        start();
        exp_mis_total = 0;
        foreach (vecs[k]) begin
            cyc(0, 1, 1, vecs[k].d, 1, vecs[k].r);
            cyc(0, 1, 0, '0, 0, '0);
            chk($sformatf("vec%0d mismatch", k), 32'(n_mismatch), 32'(vecs[k].exp_mis));
            exp_mis_total += int'(vecs[k].exp_mis);
        end
        chk("vec mismatch_count", 32'(n_mism), 32'(exp_mis_total));

        // Randomised segments against the model
        for (int seg = 0; seg < 6; seg++) begin
            for (int i = 0; i < 512; i++) begin
                rnd_d[i] = mk(16'($urandom_range(0, 7)), 8'($urandom), 1'($urandom));
                rnd_r[i] = rnd_d[i];
                if ($urandom_range(0, 19) == 0) rnd_r[i].data = rnd_r[i].data ^ 8'h80;
            end
            pd = $urandom_range(30, 100);
            pr = $urandom_range(30, 100);
            di = 0; ri = 0;
            cyc(1, 0, 0, '0, 0, '0);
            for (int c = 0; c < 400; c++) begin
                bit dv, rv, en;
                en = ($urandom_range(0, 31) != 0);
                dv = ($urandom_range(1, 100) <= pd);
                rv = ($urandom_range(1, 100) <= pr);
                cyc(0, en, dv, rnd_d[di], rv, rnd_r[ri]);
                if (dv) di++;
                if (rv) ri++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
